bless_nic: RTL and testbench
============================

Name: bless_nic

Overview:
- Node-side network interface for one bufferless router's local port (port 4).
- Transmit side: accepts packets from the host core, buffers them, and injects single-flit packets into the router only when the router's ready is high.
- Receive side: accepts every flit the router ejects, unconditionally, because a bufferless router cannot be back-pressured. It buffers the flits for the host and keeps drop and error statistics.
- One instance per mesh node, between the core and the router's port4_ci/di/co/do/ready.

Parameters:
- MY_ADDR, 4'b0000: node address, format {row[1:0], col[1:0]}. Must match the attached router's address parameter.
- ADDR_W, 4: address field width.
- CTRL_W, 16: control word width. Layout:
  - ctrl[0] = valid
  - ctrl[4:1] = dest
  - ctrl[8:5] = src
  - ctrl[15:9] = seq (SEQ_W = CTRL_W-1-2*ADDR_W = 7)
- DATA_W, 32: flit payload width.
- TX_DEPTH, 4: TX FIFO entries (power of 2).
- RX_DEPTH, 4: RX FIFO entries (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  host offers a packet
- tx_dest  in  ADDR_W  destination node
- tx_data  in  DATA_W  payload
- tx_ready  out  1  TX FIFO not full
- inj_c  out  CTRL_W  control word to router port4_ci
- inj_d  out  DATA_W  data to router port4_di
- inj_ready  in  1  router port4_ready (injection slot free this cycle)
- ej_c  in  CTRL_W  router port4_co
- ej_d  in  DATA_W  router port4_do
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  host pops the RX head
- rx_src  out  ADDR_W  source of the RX head
- rx_seq  out  SEQ_W  sequence number of the RX head
- rx_data  out  DATA_W  payload of the RX head
- drop_cnt  out  8  ejected flits dropped because RX FIFO was full (saturating)
- misroute_cnt  out  8  ejected flits whose dest != MY_ADDR (saturating)
- overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset (sync, rst=1 at posedge):
  - TX and RX FIFOs empty.
  - inj_c=0, inj_d=0, seq counter=0, drop_cnt=0, misroute_cnt=0, overflow=0.
  - Hence tx_ready=1 and rx_valid=0 in the cycle after reset.
  - Reset mid-operation discards all buffered flits; no partial injection survives.
- TX push: a packet is written when tx_valid && tx_ready at posedge. tx_ready = !tx_full, combinational on FIFO state only; it never depends on tx_valid.
- Injection (inj_c/inj_d are registered). At each posedge with the TX head valid and head dest != MY_ADDR:
  - If inj_ready=1: inj_c <= {seq, MY_ADDR, head_dest, 1'b1}, inj_d <= head_data, pop the head, seq <= seq+1 (wraps 127->0).
  - Otherwise inj_c <= 0 (valid=0) and inj_d holds its previous value.
  - One injection per cycle maximum. Latency is tx push to inj_c valid >= 2 cycles: FIFO write, then injection register.
- Loopback: when the TX head dest == MY_ADDR, the head is never sent to the router.
  - It is written directly into the RX FIFO as {src=MY_ADDR, seq, data}, consumes a seq number, and ignores inj_ready.
  - It is performed only if no valid ejected flit arrives that cycle and the RX FIFO is not full. Otherwise the head waits.
  - inj_c valid=0 in a loopback cycle.
- TX simultaneous push and pop when full: the pop frees a slot, but tx_ready was already 0, so no push occurs.
- Ejection: ej_c[0]=1 marks a valid flit, sampled every posedge with no handshake.
  - If dest != MY_ADDR: misroute_cnt++ and the flit is discarded.
  - Else if RX FIFO is not full, or a pop (rx_valid && rx_ready) occurs in the same cycle: store {src, seq, data}.
  - Else: drop_cnt++ and overflow <= 1.
- Ejection always has priority over loopback for the RX write port. At most one RX write per cycle.
- RX pop: occurs when rx_valid && rx_ready. rx_src, rx_seq and rx_data are driven combinationally from the FIFO head and are stable while rx_valid=1 and no pop occurs.
- Counters saturate at 255. overflow clears only on rst.
- FIFO pointers are log2(depth)+1 bits. full = (MSBs differ && low bits equal). empty = (pointers equal).

Test Plan:
- Basic inject: MY_ADDR=0101, inj_ready=1, push dest=1010, data=0xDEADBEEF.
  -> 2 cycles later inj_c = {seq=0, src=0101, dest=1010, 1}, inj_d=0xDEADBEEF; next injection carries seq=1.
- Back-pressure: inj_ready=0, push 5 packets.
  -> tx_ready falls after 4 accepted, inj_c valid stays 0.
  -> Raise inj_ready: 4 back-to-back injections, seq 0..3, in FIFO order.
- Ejection overflow: rx_ready=0, eject 6 valid flits dest=MY_ADDR on consecutive cycles.
  -> First 4 stored, drop_cnt=2, overflow=1.
  -> Pop all: src/seq/data match the first 4 in order.
- Misroute: eject a flit with dest=0000 at MY_ADDR=0101.
  -> misroute_cnt=1, rx_valid stays 0.
- Loopback contention: push dest=MY_ADDR while valid ejections arrive on 3 consecutive cycles.
  -> Loopback entry lands in RX after the 3 ejected flits, with src=MY_ADDR and seq=0.
- Reset mid-traffic: 3 in TX, 2 in RX, drop_cnt=5; assert rst for 1 cycle.
  -> Next cycle: tx_ready=1, rx_valid=0, inj_c=0, counters=0, overflow=0, next injection seq=0.

Source files
------------

// File: rtl/bless_nic.sv
// Network interface for the local port of a bufferless router.
// The TX path buffers host packets and injects one single-flit packet per
// cycle when the router offers a slot. Packets addressed to this node are
// looped back into the RX FIFO instead of being injected.
// The RX path accepts every ejected flit. A bufferless router cannot be
// stalled, so a flit that finds the RX FIFO full is counted and discarded.
//
// Handshakes:
//   tx_valid/tx_ready : a packet transfers at the posedge where both are 1.
//                       tx_ready depends only on FIFO state, never on tx_valid.
//   rx_valid/rx_ready : the RX head pops at the posedge where both are 1.
//                       The head fields stay stable until that pop.
//   inj_ready         : an injection slot offered by the router. There is no
//                       valid/ready pairing; the router consumes inj_c/inj_d
//                       whenever inj_c[0] is set.
//   ej_c[0]           : an ejected flit, taken unconditionally.
module bless_nic #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] MY_ADDR  = '0,
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                TX_DEPTH = 4,
  parameter int                RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [ADDR_W-1:0]           tx_dest,
  input  logic [DATA_W-1:0]           tx_data,
  output logic                        tx_ready,
  output logic [CTRL_W-1:0]           inj_c,
  output logic [DATA_W-1:0]           inj_d,
  input  logic                        inj_ready,
  input  logic [CTRL_W-1:0]           ej_c,
  input  logic [DATA_W-1:0]           ej_d,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [ADDR_W-1:0]           rx_src,
  output logic [CTRL_W-2*ADDR_W-2:0]  rx_seq,
  output logic [DATA_W-1:0]           rx_data,
  output logic [7:0]                  drop_cnt,
  output logic [7:0]                  misroute_cnt,
  output logic                        overflow
);

  localparam int SEQ_W = CTRL_W - 1 - 2 * ADDR_W;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_W  = ADDR_W + DATA_W;
  localparam int RX_W  = ADDR_W + SEQ_W + DATA_W;

  // ---------------- TX FIFO ----------------
  logic [TX_W-1:0]   tx_mem [TX_DEPTH];
  logic [TX_AW:0]    tx_wr_ptr;
  logic [TX_AW:0]    tx_rd_ptr;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign {head_dest, head_data} = tx_mem[tx_rd_ptr[TX_AW-1:0]];

  // ---------------- RX FIFO ----------------
  logic [RX_W-1:0]   rx_mem [RX_DEPTH];
  logic [RX_AW:0]    rx_wr_ptr;
  logic [RX_AW:0]    rx_rd_ptr;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic [RX_W-1:0]   rx_wdata;

  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign {rx_src, rx_seq, rx_data} = rx_mem[rx_rd_ptr[RX_AW-1:0]];

  // ---------------- Ejection decode ----------------
  logic              ej_valid;
  logic [ADDR_W-1:0] ej_dest;
  logic [ADDR_W-1:0] ej_src;
  logic [SEQ_W-1:0]  ej_seq;
  logic              ej_mine;
  logic              ej_misroute;
  logic              ej_store;
  logic              ej_drop;

  assign ej_valid    = ej_c[0];
  assign ej_dest     = ej_c[ADDR_W:1];
  assign ej_src      = ej_c[2*ADDR_W:ADDR_W+1];
  assign ej_seq      = ej_c[CTRL_W-1:2*ADDR_W+1];
  assign ej_mine     = ej_valid && (ej_dest == MY_ADDR);
  assign ej_misroute = ej_valid && (ej_dest != MY_ADDR);
  // A same-cycle pop frees the slot this flit is written into.
  assign ej_store    = ej_mine && (!rx_full || rx_pop);
  assign ej_drop     = ej_mine && rx_full && !rx_pop;

  // ---------------- TX head dispatch ----------------
  logic [SEQ_W-1:0]  seq_cnt;
  logic              do_loop;
  logic              do_inject;

  // Loopback yields the RX write port to any ejected flit, even a misrouted one.
  assign do_loop   = !tx_empty && (head_dest == MY_ADDR) && !ej_valid && !rx_full;
  assign do_inject = !tx_empty && (head_dest != MY_ADDR) && inj_ready;
  assign tx_pop    = do_loop || do_inject;

  // Ejected flits take the RX write port before loopback.
  assign rx_push  = ej_store || do_loop;
  assign rx_wdata = ej_store ? {ej_src, ej_seq, ej_d}
                             : {MY_ADDR, seq_cnt, head_data};

  // Store accepted host packets; storage is not reset, the pointers are.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {tx_dest, tx_data};
    end
  end

  // Advance TX pointers on push and on injection/loopback pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
    end
  end

  // Register the injected flit and number every dispatched packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_c   <= '0;
      inj_d   <= '0;
      seq_cnt <= '0;
    end else begin
      if (do_inject) begin
        inj_c <= {seq_cnt, MY_ADDR, head_dest, 1'b1};
        inj_d <= head_data;
      end else begin
        inj_c <= '0;
      end
      if (tx_pop) seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  // Write ejected or looped-back flits into RX storage.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_wdata;
    end
  end

  // Advance RX pointers on write and on host pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
    end
  end

  // Saturating drop/misroute statistics and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt     <= '0;
      misroute_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (ej_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (ej_misroute && (misroute_cnt != 8'hFF)) begin
        misroute_cnt <= misroute_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bless_nic.sv
// Bench for bless_nic: table-driven ejection vectors, directed corner-case
// sequences and randomized traffic, all checked against a queue-based model.
module tb_bless_nic;

  localparam logic [3:0] MY = 4'b0101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tx_valid = 1'b0;
  logic [3:0]  tx_dest = '0;
  logic [31:0] tx_data = '0;
  logic        tx_ready;
  logic [15:0] inj_c;
  logic [31:0] inj_d;
  logic        inj_ready = 1'b0;
  logic [15:0] ej_c = '0;
  logic [31:0] ej_d = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  rx_src;
  logic [6:0]  rx_seq;
  logic [31:0] rx_data;
  logic [7:0]  drop_cnt;
  logic [7:0]  misroute_cnt;
  logic        overflow;

  bless_nic #(.ADDR_W(4), .MY_ADDR(MY), .CTRL_W(16), .DATA_W(32),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_dest(tx_dest), .tx_data(tx_data), .tx_ready(tx_ready),
    .inj_c(inj_c), .inj_d(inj_d), .inj_ready(inj_ready),
    .ej_c(ej_c), .ej_d(ej_d),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_src(rx_src), .rx_seq(rx_seq), .rx_data(rx_data),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt), .overflow(overflow)
  );

  // ---------------- reference model ----------------
  logic [35:0] tx_q[$];   // {dest, data}
  logic [42:0] exp_q[$];  // {src, seq, data}
  int          m_seq;
  int          m_drop;
  int          m_mis;
  logic        m_ovf;
  logic [15:0] m_inj_c;
  logic [31:0] m_inj_d;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] mk(input int seq, input logic [3:0] src,
                                     input logic [3:0] dest);
    return {7'(seq), src, dest, 1'b1};
  endfunction

  task automatic model_reset();
    tx_q.delete();
    exp_q.delete();
    m_seq = 0; m_drop = 0; m_mis = 0; m_ovf = 1'b0;
    m_inj_c = '0; m_inj_d = '0;
  endtask

  // Next state from the current model contents and the driven inputs.
  task automatic model_step();
    int          rx_n;
    logic        pop, push, wr, lb, inj;
    logic [42:0] entry;
    logic [3:0]  hd;
    logic [31:0] hdata;
    rx_n  = exp_q.size();
    pop   = (rx_n > 0) && rx_ready;
    push  = tx_valid && (tx_q.size() < 4);
    wr    = 1'b0;
    entry = '0;
    hd    = '0;
    hdata = '0;
    if (tx_q.size() > 0) begin
      hd    = tx_q[0][35:32];
      hdata = tx_q[0][31:0];
    end
    if (ej_c[0]) begin
      if (ej_c[4:1] != MY) begin
        if (m_mis < 255) m_mis++;
      end else if (rx_n < 4 || pop) begin
        wr = 1'b1;
        entry = {ej_c[8:5], ej_c[15:9], ej_d};
      end else begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1'b1;
      end
    end
    lb  = (tx_q.size() > 0) && (hd == MY) && !ej_c[0] && (rx_n < 4);
    inj = (tx_q.size() > 0) && (hd != MY) && inj_ready;
    if (inj) begin
      m_inj_c = mk(m_seq, MY, hd);
      m_inj_d = hdata;
      m_seq = (m_seq + 1) % 128;
    end else begin
      m_inj_c = '0;
    end
    if (lb) begin
      wr = 1'b1;
      entry = {MY, 7'(m_seq), hdata};
      m_seq = (m_seq + 1) % 128;
    end
    if (inj || lb) void'(tx_q.pop_front());
    if (push) tx_q.push_back({tx_dest, tx_data});
    if (pop) void'(exp_q.pop_front());
    if (wr) exp_q.push_back(entry);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx_ready", 64'(tx_ready), 64'(tx_q.size() < 4));
    chk("rx_valid", 64'(rx_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("rx_head", {rx_src, rx_seq, rx_data}, 64'(exp_q[0]));
    end
    chk("inj_c", 64'(inj_c), 64'(m_inj_c));
    chk("inj_d", 64'(inj_d), 64'(m_inj_d));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("misroute_cnt", 64'(misroute_cnt), 64'(m_mis));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    tx_valid = 1'b0; inj_ready = 1'b0; ej_c = '0; ej_d = '0; rx_ready = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic push_tx(input logic [3:0] d, input logic [31:0] v);
    tx_valid = 1'b1; tx_dest = d; tx_data = v;
  endtask

  // ---------------- ejection vector table ----------------
  typedef struct {
    logic        v;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [6:0]  seq;
    logic [31:0] data;
    logic        stored;
    int          mis;
  } ej_vec_t;

  ej_vec_t vecs[6];

  initial begin
    int mis_acc;

    vecs[0] = '{1'b1, MY,    4'h1, 7'd5,   32'hAAAA0001, 1'b1, 0};
    vecs[1] = '{1'b1, 4'h0,  4'h2, 7'd6,   32'hAAAA0002, 1'b0, 1};
    vecs[2] = '{1'b0, MY,    4'h3, 7'd7,   32'hAAAA0003, 1'b0, 0};
    vecs[3] = '{1'b1, 4'hF,  MY,   7'd8,   32'hAAAA0004, 1'b0, 1};
    vecs[4] = '{1'b1, MY,    4'hF, 7'd127, 32'hFFFFFFFF, 1'b1, 0};
    vecs[5] = '{1'b0, 4'h0,  4'h0, 7'd0,   32'h0,        1'b0, 0};

    model_reset();
    do_reset();
    chk("reset_tx_ready", 64'(tx_ready), 64'd1);
    chk("reset_rx_valid", 64'(rx_valid), 64'd0);

    // Table: single ejected flits from an empty RX FIFO.
    mis_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ej_c = {vecs[i].seq, vecs[i].src, vecs[i].dest, vecs[i].v};
      ej_d = vecs[i].data;
      rx_ready = 1'b0;
      step();
      ej_c = '0;
      mis_acc += vecs[i].mis;
      chk("vec_rx_valid", 64'(rx_valid), 64'(vecs[i].stored));
      chk("vec_misroute", 64'(misroute_cnt), 64'(mis_acc));
      if (vecs[i].stored) begin
        chk("vec_rx_entry", {rx_src, rx_seq, rx_data},
            {vecs[i].src, vecs[i].seq, vecs[i].data});
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    end

    // Basic inject: two-cycle latency, seq increments per injection.
    do_reset();
    inj_ready = 1'b1;
    push_tx(4'b1010, 32'hDEADBEEF);
    step();
    tx_valid = 1'b0;
    chk("basic_no_early_inj", 64'(inj_c), 64'd0);
    step();
    chk("basic_inj_c", 64'(inj_c), 64'h00B5);
    chk("basic_inj_d", 64'(inj_d), 64'hDEADBEEF);
    push_tx(4'b1010, 32'h12345678);
    step();
    tx_valid = 1'b0;
    step();
    chk("basic_inj_c_seq1", 64'(inj_c), 64'h02B5);

    // Back-pressure: 4 accepted, the 5th refused, then FIFO-order drain.
    do_reset();
    inj_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_tx(4'(8 + i), 32'hA0000000 + 32'(i));
      step();
      chk("bp_tx_ready", 64'(tx_ready), 64'(i < 3));
      chk("bp_no_inj", 64'(inj_c[0]), 64'd0);
    end
    tx_valid = 1'b0;
    inj_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_inj_c", 64'(inj_c), 64'(mk(i, MY, 4'(8 + i))));
      chk("bp_inj_d", 64'(inj_d), 64'(32'hA0000000 + 32'(i)));
    end
    step();
    chk("bp_drained", 64'(inj_c[0]), 64'd0);

    // Ejection overflow: 6 flits into a 4-entry FIFO with no pops.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ej_c = mk(i, 4'(i), MY);
      ej_d = 32'hC0000000 + 32'(i);
      step();
    end
    ej_c = '0;
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_entry", {rx_src, rx_seq, rx_data},
          {4'(i), 7'(i), 32'hC0000000 + 32'(i)});
      step();
    end
    chk("ovf_empty", 64'(rx_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    rx_ready = 1'b0;

    // Misroute.
    do_reset();
    ej_c = mk(0, 4'h3, 4'h0);
    ej_d = 32'h55;
    step();
    ej_c = '0;
    chk("mis_cnt", 64'(misroute_cnt), 64'd1);
    chk("mis_rx_valid", 64'(rx_valid), 64'd0);

    // Loopback contention: three ejections win the RX port first.
    do_reset();
    inj_ready = 1'b1;
    push_tx(MY, 32'h11112222);
    for (int i = 0; i < 3; i++) begin
      ej_c = mk(10 + i, 4'h2, MY);
      ej_d = 32'hE0000000 + 32'(i);
      step();
      tx_valid = 1'b0;
    end
    ej_c = '0;
    step();
    chk("lb_no_inj", 64'(inj_c[0]), 64'd0);
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("lb_ej_entry", {rx_src, rx_seq, rx_data},
          {4'h2, 7'(10 + i), 32'hE0000000 + 32'(i)});
      step();
    end
    chk("lb_entry", {rx_src, rx_seq, rx_data}, {MY, 7'd0, 32'h11112222});
    step();
    rx_ready = 1'b0;

    // Reset mid-traffic: 3 in TX, 2 in RX, 5 drops.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ej_c = mk(i, 4'h1, MY);
      ej_d = 32'(i);
      step();
    end
    ej_c = '0;
    rx_ready = 1'b1;
    step();
    step();
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_tx(4'hA, 32'hB0 + 32'(i));
      step();
    end
    tx_valid = 1'b0;
    chk("mid_drop_cnt", 64'(drop_cnt), 64'd5);
    do_reset();
    chk("mid_tx_ready", 64'(tx_ready), 64'd1);
    chk("mid_rx_valid", 64'(rx_valid), 64'd0);
    chk("mid_inj_c", 64'(inj_c), 64'd0);
    chk("mid_drop", 64'(drop_cnt), 64'd0);
    chk("mid_mis", 64'(misroute_cnt), 64'd0);
    chk("mid_ovf", 64'(overflow), 64'd0);
    inj_ready = 1'b1;
    push_tx(4'hA, 32'h77);
    step();
    tx_valid = 1'b0;
    step();
    chk("mid_seq0", 64'(inj_c), 64'(mk(0, MY, 4'hA)));

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tx_valid  = ($urandom_range(0, 1) == 1);
        tx_dest   = ($urandom_range(0, 3) == 0) ? MY : 4'($urandom_range(0, 15));
        tx_data   = $urandom;
        inj_ready = ($urandom_range(0, 9) < 7);
        ej_d      = $urandom;
        if ($urandom_range(0, 9) < 4) begin
          ej_c = mk($urandom_range(0, 127), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 7) ? MY : 4'($urandom_range(0, 15)));
        end else begin
          ej_c = 16'($urandom) & 16'hFFFE;
        end
        rx_ready = ($urandom_range(0, 1) == 1);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
